keypad_bcd_encoder: RTL and testbench
=====================================

# keypad_bcd_encoder

- Converts ten asynchronous active-high decimal key lines into a registered 4-bit BCD code plus status.
- Synchronizes and debounces the key lines, rejects multi-key presses and emits one strobe per accepted press.
- Sits between the door-lock keypad pins and the password-entry logic; its q0..q3 output uses the same BCD bit order as the lock's decimal decode path (q0 = LSB, q3 = MSB).

## Interface
- DEBOUNCE_CYCLES, default 250000 (5 ms at 50 MHz); stable cycles required to accept a press or a release; legal range 2..2^20.
- CNT_W, default 18; counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- key0..key9  in  1 each  raw key lines, active high, asynchronous to clk.
- q0..q3  out  1 each  BCD code of the last accepted key; holds its value between presses.
- key_valid  out  1  one-cycle pulse when a new key is accepted; q0..q3 are valid in the same cycle.
- key_held  out  1  high while the accepted key remains pressed.
- key_err  out  1  one-cycle pulse when two or more keys are detected together.

## Operation
- Synchronizer: each key line passes through 2 flops. s[9:0] is the synchronized vector.
- onehot = exactly one bit of s set. multi = two or more bits set. code = index of the set bit, 0..9.
- State IDLE:
  - s==0: stay.
  - onehot: capture pat=s, cnt=0, go to DEBOUNCE.
  - multi: pulse key_err, go to RELEASE with cnt=0.
- State DEBOUNCE:
  - s==pat and cnt==DEBOUNCE_CYCLES-1: load q=code(pat), pulse key_valid, go to HELD.
  - s==pat otherwise: cnt+1.
  - s==0: go to IDLE; no output change.
  - s is a different onehot: pat=s, cnt=0; stay in DEBOUNCE.
  - multi: pulse key_err, go to RELEASE with cnt=0.
- State HELD:
  - key_held=1.
  - Any nonzero s is ignored, including added keys; no err is raised.
  - s==0: go to RELEASE with cnt=0.
- State RELEASE:
  - s==0 and cnt==DEBOUNCE_CYCLES-1: go to IDLE.
  - s==0 otherwise: cnt+1.
  - s!=0: cnt=0; stay in RELEASE; no err is raised.
- Only the BCD codes 0..9 ever appear on q; 10..15 are never output.
- key_valid and key_err are mutually exclusive, and each lasts exactly one cycle.
- All outputs are registered.

## Timing
- Reset, asynchronous and effective immediately on rst_n low:
  - q0..q3=0, key_valid=0, key_held=0, key_err=0.
  - Synchronizer flops=0, state=IDLE, cnt=0, pat=0.
- Reset released mid-press: the block starts from IDLE and re-debounces the key. A key that is still held yields a fresh key_valid.
- Press latency: raw key stable before edge 1 gives key_valid high after edge DEBOUNCE_CYCLES+3. Breakdown: 2 synchronizer edges, 1 IDLE->DEBOUNCE edge, DEBOUNCE_CYCLES count edges.
- key_held rises on the same edge as key_valid. It falls on the first edge at which s==0 is seen in HELD.
- Release lockout: IDLE is re-entered DEBOUNCE_CYCLES+1 edges after s first reads 0 in HELD, provided no bounce occurs. The earliest next key_valid follows a further DEBOUNCE_CYCLES+1 edges.
- Bounce shorter than DEBOUNCE_CYCLES never produces key_valid.
- Repeated presses of the same key each produce a key_valid, as long as a full release is debounced between them.
- Counter saturation: cnt never exceeds DEBOUNCE_CYCLES-1 and never wraps.

## Test plan
- Reset with DEBOUNCE_CYCLES=4, then hold key7 clean -> key_valid is a single pulse after edge 7; q3..q0=0111; key_held=1; key_err stays 0.
- Key3 with 2-cycle glitches before settling -> no key_valid during the glitches. Exactly one key_valid follows 4 stable synchronized cycles, with q=0011.
- Key2 and key5 asserted together -> one key_err pulse, no key_valid. Release, then press key5 -> key_valid with q=0101.
- Key9 held, key1 added, then both released -> a single key_valid with q=1001 and no key_err. IDLE is reached 5 edges after s==0.
- Sweep key0..key9, each pressed and released cleanly -> ten key_valid pulses with q = 0..9 in order. key_held drops on each release.
- Assert rst_n low while in HELD with q=0110 -> all outputs go to 0 asynchronously. Release reset with the key still down -> a new key_valid after 7 edges.

Source files
------------

// File: rtl/keypad_bcd_encoder.sv
// Decimal keypad front end: two-flop synchronizer, debounce FSM with multi-key rejection,
// registered BCD code, one-cycle accept/error strobes and a held flag.
module keypad_bcd_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 18
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key0,
    input  logic key1,
    input  logic key2,
    input  logic key3,
    input  logic key4,
    input  logic key5,
    input  logic key6,
    input  logic key7,
    input  logic key8,
    input  logic key9,
    output logic q0,
    output logic q1,
    output logic q2,
    output logic q3,
    output logic key_valid,
    output logic key_held,
    output logic key_err
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StDebounce,
        StHeld,
        StRelease
    } state_e;

    state_e           r_state;
    logic [9:0]       r_sync1;
    logic [9:0]       r_s;
    logic [9:0]       r_pat;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_q;
    logic             r_key_valid;
    logic             r_key_held;
    logic             r_key_err;

    logic [9:0] w_keys;
    logic       w_nonzero;
    logic       w_onehot;
    logic       w_multi;
    logic [3:0] w_code;

    assign w_keys = {key9, key8, key7, key6, key5, key4, key3, key2, key1, key0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_s     <= '0;
        end else begin
            r_sync1 <= w_keys;
            r_s     <= r_sync1;
        end
    end

    // Clearing the lowest set bit leaves zero only for a single-bit vector.
    always_comb begin
        w_nonzero = |r_s;
        w_onehot  = w_nonzero && ((r_s & (r_s - 10'd1)) == 10'd0);
        w_multi   = w_nonzero && !w_onehot;
    end

    always_comb begin
        w_code = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (r_pat[i]) begin
                w_code = 4'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_pat       <= '0;
            r_cnt       <= '0;
            r_q         <= 4'd0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
            r_key_err   <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            r_key_err   <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_onehot) begin
                        r_pat   <= r_s;
                        r_cnt   <= '0;
                        r_state <= StDebounce;
                    end else if (w_multi) begin
                        r_key_err <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= StRelease;
                    end
                end
                StDebounce: begin
                    if (r_s == r_pat) begin
                        if (r_cnt == CntLast) begin
                            r_q         <= w_code;
                            r_key_valid <= 1'b1;
                            r_key_held  <= 1'b1;
                            r_state     <= StHeld;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end else if (!w_nonzero) begin
                        r_state <= StIdle;
                    end else if (w_onehot) begin
                        r_pat <= r_s;
                        r_cnt <= '0;
                    end else begin
                        r_key_err <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= StRelease;
                    end
                end
                StHeld: begin
                    // Extra keys while held are deliberately ignored; only a full release matters.
                    if (!w_nonzero) begin
                        r_key_held <= 1'b0;
                        r_cnt      <= '0;
                        r_state    <= StRelease;
                    end
                end
                StRelease: begin
                    if (w_nonzero) begin
                        r_cnt <= '0;
                    end else if (r_cnt == CntLast) begin
                        r_state <= StIdle;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign q0        = r_q[0];
    assign q1        = r_q[1];
    assign q2        = r_q[2];
    assign q3        = r_q[3];
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;
    assign key_err   = r_key_err;

endmodule

// File: tb/tb_keypad_bcd_encoder.sv
// Directed plus randomized bench for keypad_bcd_encoder, compared every cycle against a
// behavioural model of the keypad rules.
module tb_keypad_bcd_encoder;

    localparam int D = 4;

    localparam int PH_IDLE = 0;
    localparam int PH_DEB  = 1;
    localparam int PH_HELD = 2;
    localparam int PH_REL  = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] keys;
    logic       q0, q1, q2, q3;
    logic       key_valid, key_held, key_err;

    int total = 0;
    int bad   = 0;

    logic [9:0] m_sync1, m_s, m_pat;
    int         m_phase, m_cnt, m_q;
    bit         m_valid, m_err;

    int n_valid, n_err, edges, at;

    always #5 clk = ~clk;

    keypad_bcd_encoder #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key0     (keys[0]),
        .key1     (keys[1]),
        .key2     (keys[2]),
        .key3     (keys[3]),
        .key4     (keys[4]),
        .key5     (keys[5]),
        .key6     (keys[6]),
        .key7     (keys[7]),
        .key8     (keys[8]),
        .key9     (keys[9]),
        .q0       (q0),
        .q1       (q1),
        .q2       (q2),
        .q3       (q3),
        .key_valid(key_valid),
        .key_held (key_held),
        .key_err  (key_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sync1 = '0;
        m_s     = '0;
        m_pat   = '0;
        m_phase = PH_IDLE;
        m_cnt   = 0;
        m_q     = 0;
        m_valid = 0;
        m_err   = 0;
    endtask

    // One clock edge of the keypad rules, using the synchronized value seen before the edge.
    task automatic model_edge(input logic [9:0] raw);
        int ones;
        ones    = $countones(m_s);
        m_valid = 0;
        m_err   = 0;
        case (m_phase)
            PH_IDLE: begin
                if (ones == 1) begin
                    m_pat = m_s; m_cnt = 0; m_phase = PH_DEB;
                end else if (ones > 1) begin
                    m_err = 1; m_cnt = 0; m_phase = PH_REL;
                end
            end
            PH_DEB: begin
                if (ones > 1) begin
                    m_err = 1; m_cnt = 0; m_phase = PH_REL;
                end else if (ones == 0) begin
                    m_phase = PH_IDLE;
                end else if (m_s != m_pat) begin
                    m_pat = m_s; m_cnt = 0;
                end else if (m_cnt == D - 1) begin
                    m_q = $clog2(m_pat); m_valid = 1; m_phase = PH_HELD;
                end else begin
                    m_cnt++;
                end
            end
            PH_HELD: begin
                if (ones == 0) begin
                    m_cnt = 0; m_phase = PH_REL;
                end
            end
            default: begin
                if (ones != 0) m_cnt = 0;
                else if (m_cnt == D - 1) m_phase = PH_IDLE;
                else m_cnt++;
            end
        endcase
        m_s     = m_sync1;
        m_sync1 = raw;
    endtask

    task automatic compare_all();
        check("q", {28'd0, q3, q2, q1, q0}, m_q);
        check("key_valid", key_valid, m_valid);
        check("key_held", key_held, m_phase == PH_HELD);
        check("key_err", key_err, m_err);
        check("q_legal", {q3, q2, q1, q0} <= 4'd9, 1);
    endtask

    task automatic cycle(input logic [9:0] raw);
        keys = raw;
        @(posedge clk);
        model_edge(raw);
        edges++;
        #1;
        compare_all();
        if (key_valid) n_valid++;
        if (key_err) n_err++;
    endtask

    task automatic hold(input logic [9:0] raw, input int n);
        for (int i = 0; i < n; i++) cycle(raw);
    endtask

    // Edge index (from the call) at which key_valid rises, or -1 when the budget runs out.
    task automatic press_measure(input logic [9:0] raw, output int edge_at);
        edges   = 0;
        edge_at = -1;
        for (int i = 0; i < 20 && edge_at < 0; i++) begin
            cycle(raw);
            if (key_valid) edge_at = edges;
        end
    endtask

    initial begin
        logic [9:0] pat;
        int         kind, len, a, b;

        rst_n = 1'b0;
        keys  = '0;
        model_reset();
        n_valid = 0;
        n_err   = 0;
        edges   = 0;
        #2;
        compare_all();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Clean key7 press
        n_valid = 0; n_err = 0;
        press_measure(10'b1 << 7, at);
        check("k7_latency", at, 7);
        check("k7_q", {q3, q2, q1, q0}, 7);
        hold(10'b1 << 7, 6);
        check("k7_held", key_held, 1);
        check("k7_one_valid", n_valid, 1);
        check("k7_no_err", n_err, 0);
        hold(10'b0, 10);

        // Key3 with 2-cycle glitches
        n_valid = 0;
        for (int i = 0; i < 3; i++) begin
            hold(10'b1 << 3, 2);
            hold(10'b0, 2);
        end
        check("glitch_no_valid", n_valid, 0);
        press_measure(10'b1 << 3, at);
        check("k3_latency", at, 7);
        check("k3_q", {q3, q2, q1, q0}, 3);
        hold(10'b1 << 3, 8);
        check("k3_one_valid", n_valid, 1);
        hold(10'b0, 10);

        // Key2 + key5 together, then key5 alone
        n_valid = 0; n_err = 0;
        hold((10'b1 << 2) | (10'b1 << 5), 8);
        check("multi_one_err", n_err, 1);
        check("multi_no_valid", n_valid, 0);
        hold(10'b0, 10);
        press_measure(10'b1 << 5, at);
        check("k5_latency", at, 7);
        check("k5_q", {q3, q2, q1, q0}, 5);
        hold(10'b0, 10);

        // Key9 held, key1 added, both released; exact-lockout re-press with key4
        n_valid = 0; n_err = 0;
        press_measure(10'b1 << 9, at);
        hold((10'b1 << 9) | (10'b1 << 1), 5);
        check("k9_one_valid", n_valid, 1);
        check("k9_no_err", n_err, 0);
        check("k9_q", {q3, q2, q1, q0}, 9);
        hold(10'b0, 2);
        check("k9_held_before_sync", key_held, 1);
        hold(10'b0, 1);
        check("k9_held_falls", key_held, 0);
        hold(10'b0, 2);
        press_measure(10'b1 << 4, at);
        check("lockout_exact", at, 7);
        check("k4_q", {q3, q2, q1, q0}, 4);
        hold(10'b0, 10);

        // Sweep key0..key9
        for (int k = 0; k < 10; k++) begin
            n_valid = 0;
            press_measure(10'b1 << k, at);
            hold(10'b1 << k, 3);
            check("sweep_one_valid", n_valid, 1);
            check("sweep_q", {q3, q2, q1, q0}, k);
            check("sweep_held", key_held, 1);
            hold(10'b0, 3);
            check("sweep_released", key_held, 0);
            hold(10'b0, 7);
        end

        // Reset while held on key6, key still down afterwards
        press_measure(10'b1 << 6, at);
        hold(10'b1 << 6, 4);
        check("k6_q", {q3, q2, q1, q0}, 6);
        check("k6_held", key_held, 1);
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        check("rst_q_zero", {q3, q2, q1, q0}, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        press_measure(10'b1 << 6, at);
        check("post_reset_latency", at, 7);
        check("post_reset_q", {q3, q2, q1, q0}, 6);
        hold(10'b0, 10);

        // Randomized segments: idle, single keys, key pairs and arbitrary vectors
        for (int seg = 0; seg < 250; seg++) begin
            kind = $urandom_range(0, 4);
            len  = $urandom_range(1, 10);
            a    = $urandom_range(0, 9);
            b    = (a + 1 + $urandom_range(0, 8)) % 10;
            case (kind)
                0:       pat = 10'b0;
                1, 2:    pat = 10'b1 << a;
                3:       pat = (10'b1 << a) | (10'b1 << b);
                default: pat = 10'($urandom);
            endcase
            hold(pat, len);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
